// File: rtl/ro_meas_pkg.sv
// Shared types and default constants for the ring-oscillator frequency meter.
package ro_meas_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } ro_meas_state_t;

  localparam int RO_CNT_W  = 16;
  localparam int RO_GATE_W = 16;
  localparam int RO_SETTLE = 4;

endpackage

// File: rtl/ro_sync_edge.sv
// Two-flop synchroniser for the asynchronous oscillator output plus a delay
// flop; rise is high for one clk cycle per synchronised rising edge.
module ro_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic sync1_r;
  logic sync2_r;
  logic sync3_r;

  // Synchroniser chain, free-running regardless of measurement state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
    end else begin
      sync1_r <= d;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  assign rise = sync2_r & ~sync3_r;

endmodule

// File: rtl/ro_freq_meter.sv
// Gate-window edge counter for the ring oscillator tile: enables the
// oscillator, lets it settle, counts synchronised rising edges, reports.
module ro_freq_meter
  import ro_meas_pkg::*;
#(
  parameter int CNT_W  = RO_CNT_W,
  parameter int GATE_W = RO_GATE_W,
  parameter int SETTLE = RO_SETTLE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              ro_out,
  output logic              ro_activate,
  output logic              busy,
  output logic              valid,
  output logic [CNT_W-1:0]  count,
  output logic              ovf
);

  localparam int ST_W = $clog2(SETTLE + 1);

  ro_meas_state_t    state_r;
  logic [ST_W-1:0]   settle_r;
  logic [GATE_W-1:0] gate_r;
  logic [CNT_W-1:0]  edge_cnt_r;
  logic              ovf_flag_r;

  logic              rise_s;
  logic [GATE_W-1:0] gate_eff_s;
  logic [CNT_W-1:0]  cnt_next_s;
  logic              ovf_next_s;

  ro_sync_edge u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ro_out),
    .rise  (rise_s)
  );

  // A zero gate request is stretched to a single-cycle window
  always_comb begin
    gate_eff_s = gate_len;
    if (gate_len == {GATE_W{1'b0}}) begin
      gate_eff_s = GATE_W'(1);
    end else begin
      gate_eff_s = gate_len;
    end
  end

  // Saturating edge-count update; overflow marks an edge lost at full scale
  always_comb begin
    cnt_next_s = edge_cnt_r;
    ovf_next_s = ovf_flag_r;
    if (rise_s && (edge_cnt_r != {CNT_W{1'b1}})) begin
      cnt_next_s = edge_cnt_r + CNT_W'(1);
      ovf_next_s = ovf_flag_r;
    end else if (rise_s) begin
      cnt_next_s = edge_cnt_r;
      ovf_next_s = 1'b1;
    end else begin
      cnt_next_s = edge_cnt_r;
      ovf_next_s = ovf_flag_r;
    end
  end

  // Measurement sequencer with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      settle_r    <= {ST_W{1'b0}};
      gate_r      <= {GATE_W{1'b0}};
      edge_cnt_r  <= {CNT_W{1'b0}};
      ovf_flag_r  <= 1'b0;
      ro_activate <= 1'b0;
      busy        <= 1'b0;
      valid       <= 1'b0;
      count       <= {CNT_W{1'b0}};
      ovf         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          valid <= 1'b0;
          if (start && !abort) begin
            gate_r      <= gate_eff_s;
            settle_r    <= ST_W'(SETTLE);
            edge_cnt_r  <= {CNT_W{1'b0}};
            ovf_flag_r  <= 1'b0;
            ro_activate <= 1'b1;
            busy        <= 1'b1;
            state_r     <= ARM;
          end
        end
        ARM: begin
          // Edges seen here are startup/stale and deliberately dropped
          if (abort) begin
            ro_activate <= 1'b0;
            busy        <= 1'b0;
            state_r     <= IDLE;
          end else if (settle_r == ST_W'(1)) begin
            state_r <= MEASURE;
          end else begin
            settle_r <= settle_r - ST_W'(1);
          end
        end
        MEASURE: begin
          if (abort) begin
            ro_activate <= 1'b0;
            busy        <= 1'b0;
            state_r     <= IDLE;
          end else begin
            edge_cnt_r <= cnt_next_s;
            ovf_flag_r <= ovf_next_s;
            if (gate_r == GATE_W'(1)) begin
              // Result includes an edge arriving in this final gate cycle
              ro_activate <= 1'b0;
              valid       <= 1'b1;
              count       <= cnt_next_s;
              ovf         <= ovf_next_s;
              state_r     <= DONE;
            end else begin
              gate_r <= gate_r - GATE_W'(1);
            end
          end
        end
        DONE: begin
          valid   <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          ro_activate <= 1'b0;
          busy        <= 1'b0;
          valid       <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule
